// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte valid/ready interface
//
// Carries one received byte from the UART front end to its consumer.
//   rx_valid : rx_data holds an unconsumed byte (driven by master)
//   rx_data  : received byte, stable while rx_valid is high (driven by master)
//   rx_ready : consumer takes the byte when rx_valid && rx_ready (driven by slave)
interface uart_rx_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;

  modport master (output rx_valid, output rx_data, input rx_ready);
  modport slave  (input rx_valid, input rx_data, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling 8N1 UART receiver with valid/ready byte output
//
// Ports:
//   clk, m_aresetn : clock, asynchronous active-low reset
//   uart_rxd       : asynchronous serial line, idles high
//   rx             : uart_rx_if master (rx_valid / rx_data / rx_ready)
//   rx_frame_err   : one-cycle pulse, stop bit sampled low
//   rx_parity_err  : one-cycle pulse, even-parity mismatch (0 unless UART_RX_PARITY_EN)
//   rx_overrun     : one-cycle pulse, good byte dropped because rx_valid was held
//   rx_break       : level, all-zero character with low stop bit, until line goes high
// Optional feature: define UART_RX_PARITY_EN for an even-parity bit after the data.
module uart_rx #(
  parameter int CYCLES_PER_BIT = 868,
  parameter int CNT_W          = 10
) (
  input  logic      clk,
  input  logic      m_aresetn,
  input  logic      uart_rxd,
  uart_rx_if.master rx,
  output logic      rx_frame_err,
  output logic      rx_parity_err,
  output logic      rx_overrun,
  output logic      rx_break
);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CYCLES_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic [7:0]       data_q, data_d;
  logic             fe_q, fe_d;
  logic             pe_q, pe_d;
  logic             ov_q, ov_d;
  logic             brk_q, brk_d;
  logic             rxd_s;
  logic             par_bad;

  assign rxd_s = sync_q[1];

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  assign par_bad = par_bad_q;
`else
  assign par_bad = 1'b0;
`endif

  always_comb begin
    sync_d  = {sync_q[0], uart_rxd};
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    valid_d = valid_q;
    data_d  = data_q;
    fe_d    = 1'b0;
    pe_d    = 1'b0;
    ov_d    = 1'b0;
    brk_d   = brk_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif

    if (valid_q && rx.rx_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxd_s) state_d = S_START;
      end
      S_START: begin
        // Mid-bit check of the start bit rejects short line glitches.
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (rxd_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            idx_d   = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rxd_s, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          par_bad_d = ^{shift_q, rxd_s};
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (!rxd_s) begin
            // Framing is judged before parity so only one flag fires.
            fe_d    = 1'b1;
            brk_d   = (shift_q == 8'h00);
            state_d = S_BREAK;
          end else if (par_bad) begin
            pe_d = 1'b1;
          end else if (!valid_q || rx.rx_ready) begin
            // An accept in this same cycle frees the holding register.
            valid_d = 1'b1;
            data_d  = shift_q;
          end else begin
            ov_d = 1'b1;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rxd_s) begin
          state_d = S_IDLE;
          brk_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      state_q <= S_IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      ov_q    <= 1'b0;
      brk_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
      ov_q    <= ov_d;
      brk_q   <= brk_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  assign rx.rx_valid   = valid_q;
  assign rx.rx_data    = data_q;
  assign rx_frame_err  = fe_q;
  assign rx_parity_err = pe_q;
  assign rx_overrun    = ov_q;
  assign rx_break      = brk_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with a character-level model
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  // Drive edge to stop-sample edge: 2 sync flops, IDLE detect, half bit,
  // 8 data bits (+ parity), stop bit.
  localparam int LAT = 3 + CPB / 2 - 1 + 9 * CPB + (PAR ? CPB : 0) + 1;

  localparam int K_GOOD = 0;
  localparam int K_FERR = 1;
  localparam int K_PERR = 2;
  localparam int K_BCLR = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic rxd = 1'b1;
  logic ready = 1'b0;
  logic fe, pe, ov, brk;

  uart_rx_if rx_if ();
  assign rx_if.rx_ready = ready;

  uart_rx #(.CYCLES_PER_BIT(CPB), .CNT_W(5)) dut (
    .clk          (clk),
    .m_aresetn    (rstn),
    .uart_rxd     (rxd),
    .rx           (rx_if.master),
    .rx_frame_err (fe),
    .rx_parity_err(pe),
    .rx_overrun   (ov),
    .rx_break     (brk)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scheduled character outcomes, written only by the stimulus process.
  int         ev_cyc [64];
  int         ev_kind[64];
  logic [7:0] ev_dat [64];
  int         ev_n = 0;

  // Expected outputs, written only by the model process.
  logic       exp_valid = 1'b0;
  logic [7:0] exp_data  = 8'h00;
  logic       exp_fe = 1'b0, exp_pe = 1'b0, exp_ov = 1'b0, exp_brk = 1'b0;
  int         ev_rd = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exp_valid <= 1'b0;
      exp_data  <= 8'h00;
      exp_fe    <= 1'b0;
      exp_pe    <= 1'b0;
      exp_ov    <= 1'b0;
      exp_brk   <= 1'b0;
      ev_rd     <= ev_n;
    end else begin
      exp_fe <= 1'b0;
      exp_pe <= 1'b0;
      exp_ov <= 1'b0;
      if (exp_valid && ready) exp_valid <= 1'b0;
      if (ev_rd < ev_n && ev_cyc[ev_rd] == cyc + 1) begin
        ev_rd <= ev_rd + 1;
        case (ev_kind[ev_rd])
          K_GOOD: begin
            if (!exp_valid || ready) begin
              exp_valid <= 1'b1;
              exp_data  <= ev_dat[ev_rd];
            end else begin
              exp_ov <= 1'b1;
            end
          end
          K_FERR: begin
            exp_fe  <= 1'b1;
            exp_brk <= (ev_dat[ev_rd] == 8'h00);
          end
          K_PERR:  exp_pe  <= 1'b1;
          default: exp_brk <= 1'b0;
        endcase
      end
    end
  end

  int n_pass = 0;
  int n_total = 0;
  int n_fe = 0, n_pe = 0, n_ov = 0;
  logic [7:0] got_q[$];
  int         got_c[$];
  int         e0 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h at cycle %0d", name, act, req, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input int k, input logic [7:0] d);
    ev_cyc[ev_n]  = c;
    ev_kind[ev_n] = k;
    ev_dat[ev_n]  = d;
    ev_n++;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    int kind;
    step();
    rxd = 1'b0;
    e0 = cyc;
    if (!stop_b) kind = K_FERR;
    else if (PAR && ((^d) ^ par_b)) kind = K_PERR;
    else kind = K_GOOD;
    push(e0 + LAT, kind, d);
    repeat (CPB - 1) step();
    for (int i = 0; i < 8; i++) begin
      step();
      rxd = d[i];
      repeat (CPB - 1) step();
    end
    if (PAR) begin
      step();
      rxd = par_b;
      repeat (CPB - 1) step();
    end
    step();
    rxd = stop_b;
    repeat (CPB - 1) step();
  endtask

  task automatic idle(input int n);
    step();
    rxd = 1'b1;
    repeat (n) step();
  endtask

  int fe0, ov0, pe0, ng;

  initial begin
    fork
      forever begin
        @(negedge clk);
        chk("rx_valid", rx_if.rx_valid, exp_valid);
        if (exp_valid || !rstn) chk("rx_data", rx_if.rx_data, exp_data);
        chk("rx_frame_err", fe, exp_fe);
        chk("rx_parity_err", pe, exp_pe);
        chk("rx_overrun", ov, exp_ov);
        chk("rx_break", brk, exp_brk);
        n_fe += int'(fe);
        n_pe += int'(pe);
        n_ov += int'(ov);
        if (rx_if.rx_valid && ready) begin
          got_q.push_back(rx_if.rx_data);
          got_c.push_back(cyc);
        end
      end
    join_none

    // Reset state
    repeat (3) step();
    chk("reset_valid", rx_if.rx_valid, 1'b0);
    chk("reset_data", rx_if.rx_data, 8'h00);
    chk("reset_break", brk, 1'b0);
    rstn = 1'b1;
    idle(8);

    // 0xA5 with ready held high: one-cycle valid at the documented latency
    ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(8);
    chk("a5_count", got_q.size(), 1);
    chk("a5_data", got_q[0], 8'hA5);
    chk("a5_latency_ok", (got_c[0] - e0 >= 2 + 8 + 144 + 1 - 1 + (PAR ? 16 : 0)) &&
                         (got_c[0] - e0 <= 2 + 8 + 144 + 1 + 1 + (PAR ? 16 : 0)), 1'b1);
    chk("a5_no_flags", n_fe + n_pe + n_ov, 0);

    // Back-to-back 0x3C, 0x7E with ready low: overrun, data held
    ready = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'h7E, 1'b1, 1'b0);
    step();
    chk("ovr_data_held", rx_if.rx_data, 8'h3C);
    chk("ovr_count", n_ov, 1);

    // Accept coinciding with load of 0x5A: new byte kept, no overrun
    fork
      send_frame(8'h5A, 1'b1, 1'b0);
      begin
        repeat (LAT) step();
        ready = 1'b1;
        step();
        ready = 1'b0;
      end
    join
    step();
    chk("simul_data", rx_if.rx_data, 8'h5A);
    chk("simul_valid", rx_if.rx_valid, 1'b1);
    chk("simul_no_ovr", n_ov, 1);
    ready = 1'b1;
    step();
    step();
    chk("ready_drops_valid", rx_if.rx_valid, 1'b0);

    // 5-cycle glitch, then 0x55
    ng = got_q.size();
    fe0 = n_fe;
    step();
    rxd = 1'b0;
    repeat (4) step();
    idle(40);
    chk("glitch_no_byte", got_q.size(), ng);
    chk("glitch_no_flag", n_fe - fe0, 0);
    send_frame(8'h55, 1'b1, 1'b0);
    idle(8);
    chk("after_glitch_data", got_q[got_q.size() - 1], 8'h55);

    // 0x0F with low stop bit, then 0x12
    fe0 = n_fe;
    ng = got_q.size();
    send_frame(8'h0F, 1'b0, PAR ? 1'b0 : 1'b0);
    chk("ferr_count", n_fe - fe0, 1);
    chk("ferr_no_break", brk, 1'b0);
    chk("ferr_no_byte", got_q.size(), ng);
    idle(32);
    send_frame(8'h12, 1'b1, 1'b0);
    idle(8);
    chk("after_ferr_data", got_q[got_q.size() - 1], 8'h12);

    // Line low for 20 bit times: break, then 0x81
    fe0 = n_fe;
    step();
    rxd = 1'b0;
    e0 = cyc;
    push(e0 + LAT, K_FERR, 8'h00);
    repeat (20 * CPB - 1) step();
    chk("break_level", brk, 1'b1);
    chk("break_ferr", n_fe - fe0, 1);
    step();
    rxd = 1'b1;
    push(cyc + 3, K_BCLR, 8'h00);
    repeat (8) step();
    chk("break_cleared", brk, 1'b0);
    idle(24);
    send_frame(8'h81, 1'b1, 1'b0);
    idle(8);
    chk("after_break_data", got_q[got_q.size() - 1], 8'h81);

`ifdef UART_RX_PARITY_EN
    pe0 = n_pe;
    ng = got_q.size();
    send_frame(8'h07, 1'b1, 1'b0);
    idle(8);
    chk("par_err_count", n_pe - pe0, 1);
    chk("par_err_no_byte", got_q.size(), ng);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(8);
    chk("par_ok_data", got_q[got_q.size() - 1], 8'h07);
`endif

    // Reset mid-frame with a byte held: everything back to reset values
    ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    idle(4);
    chk("pre_reset_valid", rx_if.rx_valid, 1'b1);
    step();
    rxd = 1'b0;
    repeat (40) step();
    rstn = 1'b0;
    #3;
    chk("mid_reset_valid", rx_if.rx_valid, 1'b0);
    chk("mid_reset_data", rx_if.rx_data, 8'h00);
    chk("mid_reset_flags", {fe, pe, ov, brk}, 4'b0000);
    rxd = 1'b1;
    repeat (4) step();
    rstn = 1'b1;
    idle(32);
    ready = 1'b1;
    send_frame(8'h42, 1'b1, 1'b0);
    idle(8);
    chk("after_reset_data", got_q[got_q.size() - 1], 8'h42);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
